// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: byte FIFO plus baud timing that drives the serializer's
// bit index, bit strobe and frame byte for 10-bit (start, 8 data LSB-first, stop) frames.
module uart_tx_ctrl #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned BAUD_DIV   = CLK_FREQ / BAUD_RATE,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       full,
    output logic       empty,
    output logic       overflow,
    output logic       busy,
    output logic       frame_done,
    output logic [3:0] num,
    output logic       sel_data,
    output logic [7:0] tx_data
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(BAUD_DIV);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BAUD_DIV / 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   OCC_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   OCC_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    localparam logic [3:0] NUM_START = 4'd0;
    localparam logic [3:0] NUM_STOP  = 4'd9;
    localparam logic [3:0] NUM_IDLE  = 4'd10;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       num_q, num_d;
    logic [7:0]       tx_data_q;
    logic             sel_q, sel_d;
    logic             fd_q, fd_d;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   occ_q, occ_d;
    logic             full_q, empty_q, ovf_q;
    logic             wr_acc, pop, bit_end;

    assign wr_acc  = wr_en & ~full_q;
    assign bit_end = (state_q == SEND) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        num_d   = num_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty_q) begin
                    pop     = 1'b1;
                    state_d = SEND;
                    num_d   = NUM_START;
                    cnt_d   = '0;
                end
            end
            SEND: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (num_q < NUM_STOP) begin
                        num_d = num_q + 4'd1;
                    end else if (!empty_q) begin
                        pop   = 1'b1;
                        num_d = NUM_START;
                    end else begin
                        state_d = IDLE;
                        num_d   = NUM_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Strobes are registered from next-state values so they line up with the counter.
        sel_d = (state_d == SEND) && (cnt_d == CNT_HALF);
        fd_d  = (state_d == SEND) && (cnt_d == CNT_LAST) && (num_d == NUM_STOP);
    end

    always_comb begin
        occ_d = occ_q;
        unique case ({wr_acc, pop})
            2'b10:   occ_d = occ_q + OCC_ONE;
            2'b01:   occ_d = occ_q - OCC_ONE;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            num_q     <= NUM_IDLE;
            tx_data_q <= '0;
            sel_q     <= 1'b0;
            fd_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
            sel_q   <= sel_d;
            fd_q    <= fd_d;
            if (pop) begin
                tx_data_q <= mem[rd_ptr_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            occ_q   <= occ_d;
            full_q  <= (occ_d == OCC_FULL);
            empty_q <= (occ_d == '0);
            ovf_q   <= wr_en & full_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    assign full       = full_q;
    assign empty      = empty_q;
    assign overflow   = ovf_q;
    assign busy       = (state_q == SEND);
    assign frame_done = fd_q;
    assign num        = num_q;
    assign sel_data   = sel_q;
    assign tx_data    = tx_data_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: frame-time reference model compared every cycle, plus
// directed scenarios with literal timing and data expectations.
module tb_uart_tx_ctrl;

    localparam int unsigned DIV   = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned FRAME = 10 * DIV;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full, empty, overflow, busy, frame_done, sel_data;
    logic [3:0] num;
    logic [7:0] tx_data;

    uart_tx_ctrl #(
        .CLK_FREQ  (8_000_000),
        .BAUD_RATE (1_000_000),
        .BAUD_DIV  (DIV),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .busy      (busy),
        .frame_done(frame_done),
        .num       (num),
        .sel_data  (sel_data),
        .tx_data   (tx_data)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // Reference model: a byte queue and the elapsed time within the current frame.
    byte unsigned mq[$];
    bit           m_full, m_empty, m_in, m_ovf, m_acc, m_pop;
    int           m_t;
    logic [7:0]   m_cur;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_full  = 1'b0;
            m_empty = 1'b1;
            m_in    = 1'b0;
            m_t     = 0;
            m_cur   = 8'h00;
            m_ovf   = 1'b0;
        end else begin
            m_acc = wr_en && !m_full;
            m_ovf = wr_en && m_full;
            m_pop = !m_empty && (!m_in || m_t == FRAME - 1);
            if (m_in) begin
                if (m_t == FRAME - 1) begin
                    m_t  = 0;
                    m_in = m_pop;
                end else begin
                    m_t++;
                end
            end else if (m_pop) begin
                m_in = 1'b1;
                m_t  = 0;
            end
            if (m_pop) m_cur = mq.pop_front();
            if (m_acc) mq.push_back(wr_data);
            m_empty = (mq.size() == 0);
            m_full  = (mq.size() == DEPTH);
        end
    end

    bit cmp_en = 1'b0;

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_busy",       busy,       m_in);
            chk("m_num",        num,        m_in ? m_t / DIV : 10);
            chk("m_sel_data",   sel_data,   m_in && (m_t % DIV) == DIV / 2);
            chk("m_frame_done", frame_done, m_in && m_t == FRAME - 1);
            chk("m_tx_data",    tx_data,    m_cur);
            chk("m_empty",      empty,      m_empty);
            chk("m_full",       full,       m_full);
            chk("m_overflow",   overflow,   m_ovf);
        end
    end

    int         n_ovf, n_fd, n_full, n_sel;
    logic [7:0] fd_data[$];

    task automatic clear_counts();
        n_ovf = 0; n_fd = 0; n_full = 0; n_sel = 0;
        fd_data.delete();
    endtask

    task automatic tick();
        @(negedge clk);
        if (overflow) n_ovf++;
        if (full) n_full++;
        if (sel_data) n_sel++;
        if (frame_done) begin
            n_fd++;
            fd_data.push_back(tx_data);
        end
    endtask

    function automatic int line_bit(input logic [3:0] n, input logic [7:0] d);
        if (n == 4'd0) return 0;
        if (n == 4'd9) return 1;
        return int'(d[n - 4'd1]);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int         t0, off, fd_off;
    int         sel_offs[$];
    int         line_bits[$];
    int         exp_line[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    bit         seen, empty_after2;
    logic [7:0] exp_b[5];

    initial begin
        // Reset held with a write pending: nothing is accepted.
        rst = 1'b1; wr_en = 1'b1; wr_data = 8'h55;
        repeat (3) begin
            @(negedge clk);
            cmp_en = 1'b1;
            chk("rst_num",   num,        4'd10);
            chk("rst_empty", empty,      1'b1);
            chk("rst_full",  full,       1'b0);
            chk("rst_busy",  busy,       1'b0);
            chk("rst_ovf",   overflow,   1'b0);
            chk("rst_sel",   sel_data,   1'b0);
            chk("rst_fd",    frame_done, 1'b0);
            chk("rst_txd",   tx_data,    8'h00);
        end
        rst = 1'b0; wr_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_empty", empty, 1'b1);
        chk("post_rst_busy",  busy,  1'b0);

        // Single frame of 8'hA5 with literal timing.
        wr_en = 1'b1; wr_data = 8'hA5; t0 = cyc; fd_off = -1;
        for (int i = 0; i < 90; i++) begin
            @(negedge clk);
            wr_en = 1'b0;
            off = cyc - t0;
            if (sel_data) begin
                sel_offs.push_back(off);
                line_bits.push_back(line_bit(num, tx_data));
            end
            if (frame_done) fd_off = off;
            if (off == 1) chk("a5_empty_t1", empty, 1'b0);
            if (off == 2) begin
                chk("a5_busy_t2", busy, 1'b1);
                chk("a5_num_t2",  num,  4'd0);
                chk("a5_txd_t2",  tx_data, 8'hA5);
            end
            if (off == 82) begin
                chk("a5_busy_t82", busy, 1'b0);
                chk("a5_num_t82",  num,  4'd10);
            end
        end
        chk("a5_pulses", sel_offs.size(), 10);
        for (int k = 0; k < 10; k++) begin
            if (k < sel_offs.size()) begin
                chk("a5_sel_off", sel_offs[k], 6 + 8 * k);
                chk("a5_line",    line_bits[k], exp_line[k]);
            end
        end
        chk("a5_fd_off", fd_off, 81);

        // Three bytes back-to-back.
        clear_counts();
        empty_after2 = 1'b0;
        wr_en = 1'b1; wr_data = 8'h01; tick();
        wr_data = 8'h02; tick();
        wr_data = 8'h03; tick();
        wr_en = 1'b0;
        for (int i = 0; i < 260; i++) begin
            seen = (n_fd == 2);
            tick();
            if (seen && n_fd == 2 && !empty_after2) begin
                empty_after2 = 1'b1;
                chk("b2b_empty_after_third_pop", empty, 1'b1);
            end
        end
        chk("b2b_fd_count", n_fd, 3);
        for (int k = 0; k < 3; k++)
            if (k < fd_data.size()) chk("b2b_txd_seq", fd_data[k], k + 1);
        chk("b2b_idle_busy", busy, 1'b0);
        chk("b2b_idle_empty", empty, 1'b1);

        // Six writes while idle: one pops, four fill, the sixth is dropped.
        clear_counts();
        for (int k = 0; k < 6; k++) begin
            wr_en = 1'b1; wr_data = 8'h10 + 8'(k);
            tick();
        end
        wr_en = 1'b0;
        for (int i = 0; i < 430; i++) tick();
        chk("six_ovf_count", n_ovf, 1);
        chk("six_full_seen", n_full > 0, 1'b1);
        chk("six_fd_count",  n_fd, 5);
        for (int k = 0; k < 5; k++)
            if (k < fd_data.size()) chk("six_txd_seq", fd_data[k], 8'h10 + k);

        // Full FIFO with a write landing on the end-of-stop pop.
        clear_counts();
        for (int k = 0; k < 5; k++) begin
            exp_b[k] = 8'h20 + 8'(k);
            wr_en = 1'b1; wr_data = exp_b[k];
            tick();
        end
        wr_en = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            tick();
            seen = frame_done;
        end
        chk("pop_fd_seen", seen, 1'b1);
        chk("pop_full_before", full, 1'b1);
        wr_en = 1'b1; wr_data = 8'h99;
        tick();
        wr_en = 1'b0;
        chk("pop_ovf", overflow, 1'b1);
        chk("pop_full_after", full, 1'b0);
        chk("pop_txd_next", tx_data, exp_b[1]);
        for (int i = 0; i < 330; i++) tick();
        chk("pop_fd_count", n_fd, 5);
        for (int k = 0; k < 5; k++)
            if (k < fd_data.size()) chk("pop_txd_seq", fd_data[k], exp_b[k]);

        // Reset mid-frame at num=4 with another byte still queued.
        wr_en = 1'b1; wr_data = 8'h3C; tick();
        wr_data = 8'hC3; tick();
        wr_en = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            tick();
            seen = (num == 4'd4);
        end
        chk("mid_num4_seen", seen, 1'b1);
        rst = 1'b1;
        tick();
        chk("mid_num",   num,      4'd10);
        chk("mid_busy",  busy,     1'b0);
        chk("mid_sel",   sel_data, 1'b0);
        chk("mid_empty", empty,    1'b1);
        chk("mid_full",  full,     1'b0);
        rst = 1'b0;
        clear_counts();
        for (int i = 0; i < 40; i++) tick();
        chk("mid_no_sel", n_sel, 0);
        chk("mid_no_fd",  n_fd,  0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- Transmit-side controller that sits directly upstream of the UART bit serializer.
- Buffers bytes from the system side in a small FIFO and generates the baud-rate timing for each frame.
- Drives the serializer's bit index (num), bit-strobe (sel_data) and held frame byte (tx_data).
- Frames are 10 bits: start, 8 data LSB-first, stop. The serializer drives the line from these three signals.

Parameters:
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD_RATE, 9600: line bit rate.
- BAUD_DIV, CLK_FREQ/BAUD_RATE: clocks per bit period, integer-truncated. Must be ≥ 4.
- FIFO_DEPTH, 4: byte FIFO entries. Power of 2, ≥ 2.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write strobe for wr_data, one byte per asserted cycle.
- wr_data  in  8  byte to transmit.
- full  out  1  FIFO full (registered).
- empty  out  1  FIFO empty (registered).
- overflow  out  1  one-cycle pulse when a write is dropped.
- busy  out  1  high while a frame is in progress.
- frame_done  out  1  one-cycle pulse at the end of each stop-bit period.
- num  out  4  bit index to serializer: 0 = start, 1..8 = data bits 0..7, 9 = stop, 10 = idle.
- sel_data  out  1  one-cycle bit strobe to serializer.
- tx_data  out  8  frame byte to serializer, stable for the whole frame.

Behaviour:
- Reset (synchronous, clk edge with rst=1):
  - FIFO emptied: empty=1, full=0.
  - overflow=0, busy=0, frame_done=0, sel_data=0.
  - num=10, tx_data=8'h00, baud counter=0, state=IDLE.
  - Reset mid-frame aborts the frame immediately. No further sel_data pulse occurs, so the serializer line returns high through its own reset.
- FIFO:
  - Write is accepted iff wr_en=1 and full=0 in that cycle.
  - wr_en=1 with full=1 drops the byte and pulses overflow the next cycle. This holds even if a pop happens in the same cycle.
  - Simultaneous write and pop with full=0 both take effect; occupancy is unchanged.
  - Pointers wrap modulo FIFO_DEPTH. full and empty are updated on the edge after the change.
- State machine, IDLE / SEND:
  - IDLE: busy=0, num=10. When empty=0: pop the head, load tx_data, set num=0, clear the baud counter, go to SEND; busy=1 from the next cycle.
  - Latency: wr_en at cycle T into an empty FIFO while IDLE → empty=0 at T+1 → pop at T+1 → SEND with num=0 at T+2.
  - SEND: the baud counter counts 0..BAUD_DIV-1 and wraps.
  - sel_data is registered. It is high for exactly one cycle per bit period, in the cycle where counter == BAUD_DIV/2.
  - On counter wrap with num<9: num increments.
  - On counter wrap with num=9: frame_done pulses one cycle.
    - FIFO non-empty: pop next byte, load tx_data, num=0, counter=0, stay in SEND. Back-to-back, no idle gap.
    - FIFO empty: num=10, busy=0, go to IDLE.
- Timing:
  - A frame occupies exactly 10*BAUD_DIV cycles in SEND.
  - Each num value 0..9 is held for exactly BAUD_DIV cycles.
  - tx_data changes only at a frame load.
- Writes during SEND are buffered normally and never disturb the current frame.

Test Plan:
- BAUD_DIV=8, FIFO_DEPTH=4; write 8'hA5 at T while idle:
  - SEND at T+2.
  - num steps 0..9, each held 8 cycles.
  - sel_data pulses at T+6, T+14, …, T+78 (10 pulses).
  - frame_done at T+81; busy low and num=10 from T+82.
  - Serializer model output: 0,1,0,1,0,0,1,0,1,1.
- Write 8'h01, 8'h02, 8'h03 on consecutive cycles:
  - Three frames back-to-back, each 80 cycles, no idle gap.
  - tx_data sequence 01, 02, 03; three frame_done pulses.
  - empty=1 after the third pop.
- Write 6 bytes on consecutive cycles while idle: the first pops and 4 fill the FIFO, so full=1; the 6th write sees full=1, gets one overflow pulse, and is dropped. Exactly 5 frames are sent.
- Full FIFO plus a write in the same cycle as the end-of-stop pop:
  - The write is dropped and overflow pulses.
  - Occupancy goes 4→3, full=0 the next cycle.
- Assert rst for one cycle at num=4 mid-frame: next cycle num=10, busy=0, sel_data=0, empty=1. No further sel_data until a new write.
- Reset held high with wr_en=1: no byte is accepted and all outputs stay at their reset values.
